// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the framebuffer port arbiter (slave) and its requesters plus the framebuffer RAM (master).
// Carries the LCD/CPU read and write handshakes, the clear controls and the RAM port signals.
interface fb_port_arbiter_if;
  logic        lcd_req;
  logic [31:0] lcd_addr;
  logic        lcd_ack;
  logic        lcd_rvalid;

  logic        cpu_rreq;
  logic [31:0] cpu_raddr;
  logic        cpu_rack;
  logic        cpu_rvalid;
  logic [7:0]  rdata;

  logic        cpu_wreq;
  logic [31:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wack;

  logic        clr_start;
  logic [7:0]  clr_value;
  logic        clr_busy;
  logic        clr_done;

  logic [31:0] fb_rad;
  logic [31:0] fb_wad;
  logic        fb_wre;
  logic [7:0]  fb_din;
  logic [7:0]  fb_dout;

  modport master (
    output lcd_req, lcd_addr, cpu_rreq, cpu_raddr, cpu_wreq, cpu_waddr, cpu_wdata,
           clr_start, clr_value, fb_dout,
    input  lcd_ack, lcd_rvalid, cpu_rack, cpu_rvalid, rdata, cpu_wack,
           clr_busy, clr_done, fb_rad, fb_wad, fb_wre, fb_din
  );

  modport slave (
    input  lcd_req, lcd_addr, cpu_rreq, cpu_raddr, cpu_wreq, cpu_waddr, cpu_wdata,
           clr_start, clr_value, fb_dout,
    output lcd_ack, lcd_rvalid, cpu_rack, cpu_rvalid, rdata, cpu_wack,
           clr_busy, clr_done, fb_rad, fb_wad, fb_wre, fb_din
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: LCD scanout / CPU reads share the read port, CPU writes / clear engine share the write port.
// Optional clear engine built when FB_CLEAR_EN is defined.
module fb_port_arbiter #(
  parameter int unsigned FBSIZE     = 76800,
  parameter int unsigned STARVE_MAX = 15
) (
  input logic              clk,
  input logic              reset_n,
  fb_port_arbiter_if.slave bus
);
  localparam int unsigned    AW         = (FBSIZE > 1) ? $clog2(FBSIZE) : 1;
  localparam logic [31:0]    FBSIZE_W   = 32'(FBSIZE);
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(FBSIZE - 1);
  localparam logic [7:0]     STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]    starve_q, starve_d;
  logic          cpu_win, lcd_grant, cpu_grant, rd_grant;
  logic [31:0]   rd_addr;
  logic          rd_in_range;
  logic [AW-1:0] rad_q;
  logic          s1_valid_q, s1_cpu_q, s1_oor_q;
  logic          lcd_rvalid_q, cpu_rvalid_q, s2_oor_q;

  logic          cpu_wgrant, wr_in_range;
  logic [AW-1:0] wad_q;
  logic [7:0]    din_q;
  logic          wre_q;

  logic          clr_busy, clr_done, clr_fill, clr_accept;
  logic [AW-1:0] clr_addr;
  logic [7:0]    clr_val;

  // Read arbitration: LCD has priority until a waiting CPU read has seen STARVE_MAX LCD grants.
  always_comb begin
    cpu_win     = bus.cpu_rreq & (~bus.lcd_req | (starve_q == STARVE_LIM));
    lcd_grant   = reset_n & bus.lcd_req & ~cpu_win;
    cpu_grant   = reset_n & cpu_win;
    rd_grant    = lcd_grant | cpu_grant;
    rd_addr     = cpu_win ? bus.cpu_raddr : bus.lcd_addr;
    rd_in_range = rd_addr < FBSIZE_W;
    starve_d    = starve_q;
    if (!bus.cpu_rreq || cpu_grant) begin
      starve_d = '0;
    end else if (lcd_grant && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Two-stage tag pipeline tracks owner and range of each read alongside the RAM latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q     <= '0;
      rad_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_cpu_q     <= 1'b0;
      s1_oor_q     <= 1'b0;
      lcd_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      s2_oor_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if (rd_grant && rd_in_range) begin
        rad_q <= rd_addr[AW-1:0];
      end
      s1_valid_q   <= rd_grant;
      s1_cpu_q     <= cpu_grant;
      s1_oor_q     <= rd_grant & ~rd_in_range;
      lcd_rvalid_q <= s1_valid_q & ~s1_cpu_q;
      cpu_rvalid_q <= s1_valid_q & s1_cpu_q;
      s2_oor_q     <= s1_oor_q;
    end
  end

  assign bus.lcd_ack    = lcd_grant;
  assign bus.cpu_rack   = cpu_grant;
  assign bus.lcd_rvalid = lcd_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.rdata      = ((lcd_rvalid_q | cpu_rvalid_q) & ~s2_oor_q) ? bus.fb_dout : '0;
  assign bus.fb_rad     = 32'(rad_q);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_FILL,
    CLR_DONE
  } clr_state_e;

  clr_state_e    state_q;
  logic [AW-1:0] clr_addr_q;
  logic [7:0]    clr_val_q;
  logic          clr_busy_q, clr_done_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLR_IDLE;
      clr_addr_q <= '0;
      clr_val_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (bus.clr_start) begin
            state_q    <= CLR_FILL;
            clr_addr_q <= '0;
            clr_val_q  <= bus.clr_value;
            clr_busy_q <= 1'b1;
          end
        end
        CLR_FILL: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= CLR_DONE;
            clr_done_q <= 1'b1;
          end
        end
        CLR_DONE: begin
          state_q    <= CLR_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= CLR_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
  assign clr_fill   = (state_q == CLR_FILL);
  assign clr_accept = (state_q == CLR_IDLE) & bus.clr_start;
  assign clr_addr   = clr_addr_q;
  assign clr_val    = clr_val_q;
`else
  logic unused_clr;
  assign unused_clr = ^{bus.clr_start, bus.clr_value, LAST_ADDR};
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign clr_fill   = 1'b0;
  assign clr_accept = 1'b0;
  assign clr_addr   = '0;
  assign clr_val    = '0;
`endif

  // A clear starting this cycle owns the write port, so the CPU is held off in the same cycle.
  assign cpu_wgrant  = reset_n & bus.cpu_wreq & ~clr_busy & ~clr_accept;
  assign wr_in_range = bus.cpu_waddr < FBSIZE_W;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wad_q <= '0;
      din_q <= '0;
      wre_q <= 1'b0;
    end else if (clr_fill) begin
      wad_q <= clr_addr;
      din_q <= clr_val;
      wre_q <= 1'b1;
    end else if (cpu_wgrant && wr_in_range) begin
      wad_q <= bus.cpu_waddr[AW-1:0];
      din_q <= bus.cpu_wdata;
      wre_q <= 1'b1;
    end else begin
      wre_q <= 1'b0;
    end
  end

  assign bus.cpu_wack = cpu_wgrant;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;
  assign bus.fb_wad   = 32'(wad_q);
  assign bus.fb_din   = din_q;
  assign bus.fb_wre   = wre_q;
endmodule
